// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// imem_addr is held stable by the master from imem_req rising until the imem_ack cycle.
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface : instr_fetch_if

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding instruction-memory read, a one-entry skid buffer for
// words returned during a decode stall, and redirect handling that discards stale returns.
module instr_fetch (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [63:0]          br_target,
  instr_fetch_if.master        imem,
  output logic                 id_valid,
  output logic [31:0]          id_inst,
  output logic [63:0]          id_pc
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [63:0] id_pc_q, id_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [63:0] skid_pc_q, skid_pc_d;

  logic take_word;
  logic drain_skid;

  // A returned word is usable only in REQ; in KILL it belongs to a squashed path.
  assign take_word  = (state_q == S_REQ) && imem.imem_ack;
  assign drain_skid = (state_q == S_HOLD) && !stall;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_ack) begin
          state_d = (stall && !br_taken) ? S_HOLD : S_REQ;
        end else if (br_taken) begin
          state_d = S_KILL;
        end
      end
      S_HOLD: begin
        if (br_taken || !stall) state_d = S_REQ;
      end
      S_KILL: begin
        if (imem.imem_ack) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    imem.imem_req = (state_q == S_REQ) || (state_q == S_KILL);
  end

  assign imem.imem_addr = req_addr_q;
  assign id_valid       = id_valid_q;
  assign id_inst        = id_inst_q;
  assign id_pc          = id_pc_q;

  // ---------------------------------------------------------------- datapath next
  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    id_valid_d  = id_valid_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (br_taken) begin
      // Redirect wins over stall: squash IF/ID and the skid, realign the target.
      pc_d        = {br_target[63:2], 2'b00};
      id_valid_d  = 1'b0;
      id_inst_d   = '0;
      id_pc_d     = '0;
      skid_inst_d = '0;
      skid_pc_d   = '0;
    end else if (take_word && !stall) begin
      id_valid_d = 1'b1;
      id_inst_d  = imem.imem_rdata;
      id_pc_d    = req_addr_q;
      pc_d       = pc_q + 64'd4;
    end else if (take_word) begin
      skid_inst_d = imem.imem_rdata;
      skid_pc_d   = req_addr_q;
    end else if (drain_skid) begin
      id_valid_d  = 1'b1;
      id_inst_d   = skid_inst_q;
      id_pc_d     = skid_pc_q;
      pc_d        = pc_q + 64'd4;
      skid_inst_d = '0;
      skid_pc_d   = '0;
    end else if (!stall) begin
      // Decode consumed the previous word and nothing new arrived: insert a bubble.
      id_valid_d = 1'b0;
      id_inst_d  = '0;
      id_pc_d    = '0;
    end

    // A fresh request starts whenever REQ is entered or the current one completes.
    if ((state_d == S_REQ) && ((state_q != S_REQ) || imem.imem_ack)) begin
      req_addr_d = pc_d;
    end
  end

  // ---------------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the skid entry is reset along with everything else so a stale word
      // can never be drained after reset.
      pc_q        <= '0;
      req_addr_q  <= '0;
      id_valid_q  <= 1'b0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

endmodule : instr_fetch
